// File: rtl/dlx_pkg.sv
// Shared DLX pipeline package.
// Holds the default register-file geometry and the index/word types used
// by the decode/writeback stages and their testbenches.
package dlx_pkg;

    localparam int NREG_DEF = 32;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;

    typedef logic [AW_DEF-1:0] reg_idx_t;
    typedef logic [DW_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_rdport.sv
// One read port of the multi-port register file.
// Selects a word from the storage array, forces index 0 to zero, forwards
// a same-cycle write (write-through bypass) and reports the busy state of
// the addressed register. With READ_LAT=1 the result is captured under
// rd_en and presented one cycle later.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   rd_en        capture enable (READ_LAT=1 only)
//   rd_addr      register index for this port
//   mem          storage array owned by the top level
//   busy_vec     scoreboard owned by the top level
//   wr_en/wr_addr/wr_data   the write port, for bypass and hazard resolution
//   rd_data      read result
//   rd_busy      addressed register still has a pending producer
module regfile_rdport
    import dlx_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int READ_LAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] mem [NREG],
    input  logic [NREG-1:0] busy_vec,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          rd_busy
);

    logic          rd_hit;
    logic [DW-1:0] rd_word;
    logic          rd_busy_c;

    // Combinational read: index 0 always yields zero, even when the write
    // port targets it; otherwise a matching write is forwarded so the
    // consumer sees the value being written this cycle. A matching write
    // also retires the producer, so the hazard is reported as resolved.
    always_comb begin
        rd_hit    = wr_en && (wr_addr == rd_addr);
        rd_word   = mem[rd_addr];
        if (rd_addr == '0) begin
            rd_word = '0;
        end else if (rd_hit) begin
            rd_word = wr_data;
        end
        rd_busy_c = busy_vec[rd_addr] & ~rd_hit;
    end

    generate
        if (READ_LAT == 1) begin : g_registered
            // Registered read: capture the combinational result (bypass
            // included) only when the port is enabled, otherwise hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data <= '0;
                    rd_busy <= 1'b0;
                end else if (rd_en) begin
                    rd_data <= rd_word;
                    rd_busy <= rd_busy_c;
                end
            end
        end else begin : g_combinational
            assign rd_data = rd_word;
            assign rd_busy = rd_busy_c;

            // The clock, reset and enable have no role in a combinational port.
            logic unused_lat0;
            assign unused_lat0 = &{1'b0, clk, rst_n, rd_en};
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the DLX pipeline.
// NUM_RD read ports, one write port, write-through bypass on every read
// port, and a per-register busy scoreboard set at issue and cleared at
// writeback. Register 0 is hardwired to zero and is never busy.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   wr_en/wr_addr/wr_data    writeback port
//   rd_en                    per-port capture enable (READ_LAT=1)
//   rd_addr                  packed read indices, port p at [p*AW +: AW]
//   rd_data                  packed read data, port p at [p*DW +: DW]
//   rd_busy                  per-port busy flag of the addressed register
//   sb_set_en/sb_set_addr    issue stage marks a destination busy
//   busy_vec                 full scoreboard, bit i = register i busy
module regfile_mp
    import dlx_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int NUM_RD   = 2,
    parameter int READ_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [NUM_RD-1:0]    rd_en,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    output logic [NREG-1:0]      busy_vec
);

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy;

    logic wr_valid;
    logic set_valid;

    assign wr_valid  = wr_en && (wr_addr != '0);
    assign set_valid = sb_set_en && (sb_set_addr != '0);

    // Storage: index 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_valid) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Scoreboard: writeback clears, issue sets. The set is applied last so
    // that a new producer issued in the same cycle as the old one retires
    // keeps the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wr_valid) begin
                busy[wr_addr] <= 1'b0;
            end
            if (set_valid) begin
                busy[sb_set_addr] <= 1'b1;
            end
        end
    end

    assign busy_vec = busy;

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rdport
            regfile_rdport #(
                .NREG     (NREG),
                .AW       (AW),
                .DW       (DW),
                .READ_LAT (READ_LAT)
            ) u_rdport (
                .clk      (clk),
                .rst_n    (rst_n),
                .rd_en    (rd_en[p]),
                .rd_addr  (rd_addr[p*AW +: AW]),
                .mem      (mem),
                .busy_vec (busy),
                .wr_en    (wr_en),
                .wr_addr  (wr_addr),
                .wr_data  (wr_data),
                .rd_data  (rd_data[p*DW +: DW]),
                .rd_busy  (rd_busy[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: one combinational-read and one registered-read
// instance share all inputs and are compared against a behavioural model.
module tb_regfile_mp;
    import dlx_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    reg_idx_t    wr_addr;
    word_t       wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        sb_set_en;
    reg_idx_t    sb_set_addr;

    logic [63:0] u0_rd_data;
    logic [1:0]  u0_rd_busy;
    logic [31:0] u0_busy_vec;
    logic [63:0] u1_rd_data;
    logic [1:0]  u1_rd_busy;
    logic [31:0] u1_busy_vec;

    int checks;
    int errors;

    word_t       mmem [32];
    logic [31:0] mbusy;
    word_t       mregd [2];
    logic [1:0]  mregb;

    typedef struct packed {
        logic       we;
        reg_idx_t   wa;
        word_t      wd;
        logic       se;
        reg_idx_t   sa;
        logic [1:0] re;
        reg_idx_t   a0;
        reg_idx_t   a1;
        word_t      exp_d0;
        word_t      exp_d1;
        logic       exp_b1;
    } vec_t;

    vec_t vecs [18];

    regfile_mp #(.NREG(32), .AW(5), .DW(32), .NUM_RD(2), .READ_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(u0_rd_data), .rd_busy(u0_rd_busy),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(u0_busy_vec)
    );

    regfile_mp #(.NREG(32), .AW(5), .DW(32), .NUM_RD(2), .READ_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(u1_rd_data), .rd_busy(u1_rd_busy),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(u1_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic reg_idx_t portAddr(input int p);
        return rd_addr[p*5 +: 5];
    endfunction

    // Value a reader sees this cycle: zero register, then forwarded write, then storage.
    function automatic word_t expData(input reg_idx_t a);
        if (a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return mmem[a];
    endfunction

    function automatic logic expBusy(input reg_idx_t a);
        return mbusy[a] && !(wr_en && wr_addr == a);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mmem[i] = '0;
        mbusy = '0;
        mregd[0] = '0;
        mregd[1] = '0;
        mregb = '0;
    endtask

    task automatic modelEdge();
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
                mregd[p] = expData(portAddr(p));
                mregb[p] = expBusy(portAddr(p));
            end
        end
        if (wr_en && wr_addr != 0) begin
            mmem[wr_addr] = wr_data;
            mbusy[wr_addr] = 1'b0;
        end
        if (sb_set_en && sb_set_addr != 0) mbusy[sb_set_addr] = 1'b1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " u0.d0"}, u0_rd_data[31:0], expData(portAddr(0)));
        checkVal({tag, " u0.d1"}, u0_rd_data[63:32], expData(portAddr(1)));
        checkVal({tag, " u0.busy"}, {30'b0, u0_rd_busy},
                 {30'b0, expBusy(portAddr(1)), expBusy(portAddr(0))});
        checkVal({tag, " u0.busy_vec"}, u0_busy_vec, mbusy);
        checkVal({tag, " u1.d0"}, u1_rd_data[31:0], mregd[0]);
        checkVal({tag, " u1.d1"}, u1_rd_data[63:32], mregd[1]);
        checkVal({tag, " u1.busy"}, {30'b0, u1_rd_busy}, {30'b0, mregb});
        checkVal({tag, " u1.busy_vec"}, u1_busy_vec, mbusy);
    endtask

    task automatic applyStimulus(input logic we, input reg_idx_t wa, input word_t wd,
                                 input logic se, input reg_idx_t sa, input logic [1:0] re,
                                 input reg_idx_t a0, input reg_idx_t a1);
        @(negedge clk);
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        sb_set_en = se;
        sb_set_addr = sa;
        rd_en = re;
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        modelEdge();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        sb_set_en = 1'b0;
        sb_set_addr = '0;
        rd_en = '0;
        rd_addr = '0;
        modelReset();

        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd0,  5'd31, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  2'b11, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  2'b11, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  2'b11, 5'd0,  5'd7,  32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  2'b11, 5'd9,  5'd9,  32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd9,  5'd9,  32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b1, 5'd9,  32'h1,        1'b0, 5'd0,  2'b11, 5'd9,  5'd9,  32'h1,        32'h1,        1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd9,  5'd9,  32'h1,        32'h1,        1'b0};
        vecs[10] = '{1'b1, 5'd9,  32'h2,        1'b1, 5'd9,  2'b11, 5'd9,  5'd9,  32'h2,        32'h2,        1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd9,  5'd9,  32'h2,        32'h2,        1'b1};
        vecs[12] = '{1'b1, 5'd9,  32'h3,        1'b1, 5'd12, 2'b11, 5'd12, 5'd9,  32'h0,        32'h3,        1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd9,  5'd12, 32'h3,        32'h0,        1'b1};
        vecs[14] = '{1'b1, 5'd3,  32'h55,       1'b0, 5'd0,  2'b01, 5'd3,  5'd3,  32'h55,       32'h55,       1'b0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b00, 5'd4,  5'd4,  32'h0,        32'h0,        1'b0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b00, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[17] = '{1'b1, 5'd12, 32'h0000ABCD, 1'b1, 5'd9,  2'b01, 5'd3,  5'd12, 32'h55,       32'h0000ABCD, 1'b0};

        // Reset held: every index reads zero on every port, scoreboard empty.
        #2;
        for (int i = 0; i < 32; i++) begin
            rd_addr = {i[4:0], i[4:0]};
            #1;
            checkVal($sformatf("reset u0.d0[%0d]", i), u0_rd_data[31:0], 32'h0);
            checkVal($sformatf("reset u0.d1[%0d]", i), u0_rd_data[63:32], 32'h0);
            checkVal($sformatf("reset u1.d0[%0d]", i), u1_rd_data[31:0], 32'h0);
            checkVal($sformatf("reset u1.d1[%0d]", i), u1_rd_data[63:32], 32'h0);
        end
        checkVal("reset busy_vec", u0_busy_vec | u1_busy_vec, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr = '0;
        stepEdge();

        // Directed vectors.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].se, vecs[i].sa,
                          vecs[i].re, vecs[i].a0, vecs[i].a1);
            checkVal($sformatf("vec%0d d0", i), u0_rd_data[31:0], vecs[i].exp_d0);
            checkVal($sformatf("vec%0d d1", i), u0_rd_data[63:32], vecs[i].exp_d1);
            checkVal($sformatf("vec%0d b1", i), {31'b0, u0_rd_busy[1]}, {31'b0, vecs[i].exp_b1});
            checkOutput($sformatf("vec%0d", i));
            stepEdge();
        end

        // Asynchronous reset between edges clears scoreboard and registered data at once.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd3, 5'd3);
        checkVal("pre-reset busy_vec", u1_busy_vec, 32'h00000200);
        checkVal("pre-reset u1.d0", u1_rd_data[31:0], 32'h55);
        checkOutput("pre-reset");
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkVal("async-reset u0.busy_vec", u0_busy_vec, 32'h0);
        checkVal("async-reset u1.busy_vec", u1_busy_vec, 32'h0);
        checkVal("async-reset u1.d0", u1_rd_data[31:0], 32'h0);
        checkVal("async-reset u1.busy", {30'b0, u1_rd_busy}, 32'h0);
        checkVal("async-reset u0.d0", u0_rd_data[31:0], 32'h0);

        // Write attempted across an edge while reset is held must be lost.
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_addr = {5'd5, 5'd5};
        #1;
        checkVal("reset-write u0.d0", u0_rd_data[31:0], 32'h0);
        checkOutput("post-reset");
        stepEdge();

        // Randomized traffic, biased toward a few low indices to provoke hits.
        for (int i = 0; i < 400; i++) begin
            reg_idx_t wa, sa, a0, a1;
            wa = ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom_range(0, 31)) : reg_idx_t'($urandom_range(0, 7));
            sa = ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom_range(0, 31)) : reg_idx_t'($urandom_range(0, 7));
            a0 = reg_idx_t'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 1) == 0) ? a0 : reg_idx_t'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), wa, word_t'($urandom),
                          1'($urandom_range(0, 1)), sa, 2'($urandom_range(0, 3)), a0, a1);
            checkOutput($sformatf("rand%0d", i));
            stepEdge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
